// File: rtl/knn_pkg.sv
// knn_pkg: shared types for the k_vote KNN type voter.
// FSM states, tie policy codes and vote-counter width.
package knn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SCAN,
    TIE,
    OUT
  } state_e;

  localparam int TIE_LOWEST  = 0;
  localparam int TIE_NEAREST = 1;

  // Wide enough for the rank-weighted total K(K+1)/2.
  function automatic int cnt_w(input int k);
    return $clog2(k * (k + 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/k_vote_if.sv
// k_vote_if: query-in / result-out handshake bundle for k_vote.
// master = sorter/sink side, slave = k_vote.
interface k_vote_if
  import knn_pkg::*;
#(
  parameter int K      = 5,
  parameter int TYPE_W = 2,
  parameter int CNT_W  = cnt_w(K)
);
  logic                in_valid;
  logic                in_ready;
  logic [TYPE_W*K-1:0] k_types;
  logic                out_valid;
  logic                out_ready;
  logic [TYPE_W-1:0]   inferred_type;
  logic [CNT_W-1:0]    vote_count;
  logic                tie;

  modport master (
    output in_valid, k_types, out_ready,
    input  in_ready, out_valid,
    input  inferred_type, vote_count, tie
  );

  modport slave (
    input  in_valid, k_types, out_ready,
    output in_ready, out_valid,
    output inferred_type, vote_count, tie
  );
endinterface

// File: rtl/k_vote.sv
// k_vote: KNN vote counter, argmax scan and tie resolution.
// Ports: clk, rst (sync, active-low), bus (k_vote_if.slave).
// Define K_VOTE_DIST_WEIGHT_EN for rank weights K-j.
module k_vote
  import knn_pkg::*;
#(
  parameter int K        = 5,
  parameter int TYPE_W   = 2,
  parameter int N_TYPES  = 1 << TYPE_W,
  parameter int TIE_MODE = TIE_LOWEST
) (
  input  logic     clk,
  input  logic     rst,
  k_vote_if.slave  bus
);
  localparam int CNT_W = cnt_w(K);
  localparam int JW    = (K > 1) ? $clog2(K) : 1;
  localparam int NC    = 1 << TYPE_W;

  state_e              state_q;
  logic [TYPE_W*K-1:0] types_q;
  logic [CNT_W-1:0]    cnt_q [NC];
  logic [JW-1:0]       j_q;
  logic [TYPE_W-1:0]   t_q;
  logic [TYPE_W-1:0]   best_q;
  logic [CNT_W-1:0]    max_q;
  logic                tie_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [TYPE_W-1:0] lbl;
  logic              lbl_ok;
  logic [CNT_W-1:0]  wgt;
  logic [CNT_W-1:0]  lbl_cnt;
  logic [CNT_W-1:0]  t_cnt;
  logic              j_last;
  logic              t_last;
  logic              scan_gt;
  logic              scan_eq;

  always_comb begin
    lbl     = types_q[int'(j_q)*TYPE_W +: TYPE_W];
    lbl_ok  = int'(lbl) < N_TYPES;
    lbl_cnt = cnt_q[lbl];
    t_cnt   = cnt_q[t_q];
`ifdef K_VOTE_DIST_WEIGHT_EN
    wgt     = CNT_W'(K - int'(j_q));
`else
    wgt     = CNT_W'(1);
`endif
    j_last  = int'(j_q) == K - 1;
    t_last  = int'(t_q) == N_TYPES - 1;
    scan_gt = t_cnt > max_q;
    // Zero counts never tie: all-invalid input reports no tie.
    scan_eq = (t_cnt == max_q) && (max_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      types_q     <= '0;
      for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      j_q         <= '0;
      t_q         <= '0;
      best_q      <= '0;
      max_q       <= '0;
      tie_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            types_q    <= bus.k_types;
            for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (lbl_ok) cnt_q[lbl] <= lbl_cnt + wgt;
          if (j_last) begin
            t_q     <= '0;
            max_q   <= '0;
            best_q  <= '0;
            tie_q   <= 1'b0;
            state_q <= SCAN;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        SCAN: begin
          if (scan_gt) begin
            max_q  <= t_cnt;
            best_q <= t_q;
            tie_q  <= 1'b0;
          end else if (scan_eq) begin
            tie_q <= 1'b1;
          end
          if (t_last) begin
            j_q <= '0;
            if (TIE_MODE == TIE_NEAREST &&
                !scan_gt && (tie_q || scan_eq))
              state_q <= TIE;
            else
              state_q <= OUT;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        TIE: begin
          if (lbl_ok && lbl_cnt == max_q) begin
            best_q  <= lbl;
            state_q <= OUT;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        OUT: begin
          // Result regs are final here; raise valid one cycle later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.inferred_type = best_q;
  assign bus.vote_count    = max_q;
  assign bus.tie           = tie_q;

endmodule

// File: tb/tb_k_vote.sv
// tb_k_vote: self-checking bench for k_vote.
// Three instances: lowest-tie, nearest-tie, N_TYPES=3.
module tb_k_vote;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  k_vote_if #(.K(5), .TYPE_W(2)) b0 ();
  k_vote_if #(.K(5), .TYPE_W(2)) b1 ();
  k_vote_if #(.K(5), .TYPE_W(2)) b2 ();

  k_vote #(.K(5), .TYPE_W(2), .N_TYPES(4), .TIE_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  k_vote #(.K(5), .TYPE_W(2), .N_TYPES(4), .TIE_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  k_vote #(.K(5), .TYPE_W(2), .N_TYPES(3), .TIE_MODE(0))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  logic       iv   [3];
  logic [9:0] kt   [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic [1:0] it   [3];
  logic [3:0] vc   [3];
  logic       ti   [3];

  assign b0.in_valid  = iv[0];
  assign b0.k_types   = kt[0];
  assign b0.out_ready = ordy[0];
  assign b1.in_valid  = iv[1];
  assign b1.k_types   = kt[1];
  assign b1.out_ready = ordy[1];
  assign b2.in_valid  = iv[2];
  assign b2.k_types   = kt[2];
  assign b2.out_ready = ordy[2];

  assign ir[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign it[0] = b0.inferred_type;
  assign vc[0] = b0.vote_count;
  assign ti[0] = b0.tie;
  assign ir[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign it[1] = b1.inferred_type;
  assign vc[1] = b1.vote_count;
  assign ti[1] = b1.tie;
  assign ir[2] = b2.in_ready;
  assign ov[2] = b2.out_valid;
  assign it[2] = b2.inferred_type;
  assign vc[2] = b2.vote_count;
  assign ti[2] = b2.tie;

  function automatic logic [9:0] pk(input int a, input int b,
                                    input int c, input int d,
                                    input int e);
    pk = {e[1:0], d[1:0], c[1:0], b[1:0], a[1:0]};
  endfunction

  function automatic int weight(input int j);
`ifdef K_VOTE_DIST_WEIGHT_EN
    return 5 - j;
`else
    return 1 + 0 * j;
`endif
  endfunction

  // Vote tally from the rules: per-class sums, max, winners.
  task automatic model(input int nt, input int mode,
                       input logic [9:0] v,
                       output int et, output int ec,
                       output bit etie, output int elat);
    int cnt [4];
    int mx;
    int nwin;
    int l;
    bit found;
    for (int t = 0; t < 4; t++) cnt[t] = 0;
    for (int j = 0; j < 5; j++) begin
      l = int'(v[j*2 +: 2]);
      if (l < nt) cnt[l] += weight(j);
    end
    mx = 0;
    for (int t = 0; t < nt; t++) if (cnt[t] > mx) mx = cnt[t];
    nwin = 0;
    et = -1;
    for (int t = 0; t < nt; t++)
      if (cnt[t] == mx) begin
        nwin++;
        if (et < 0) et = t;
      end
    etie = (mx > 0) && (nwin > 1);
    ec = mx;
    elat = 1 + 5 + nt;
    found = 0;
    if (etie && mode == 1)
      for (int j = 0; j < 5; j++) begin
        l = int'(v[j*2 +: 2]);
        if (!found && l < nt && cnt[l] == mx) begin
          et = l;
          elat += j + 1;
          found = 1;
        end
      end
  endtask

  task automatic run_query(input int idx, input logic [9:0] v,
                           input int hold, input string nm);
    int et, ec, elat, lat, nt, mode;
    bit etie, bad;
    logic [1:0] s_it;
    logic [3:0] s_vc;
    logic s_ti;
    nt   = (idx == 2) ? 3 : 4;
    mode = (idx == 1) ? 1 : 0;
    model(nt, mode, v, et, ec, etie, elat);
    lat = 0;
    while (!ir[idx] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    n_run++;
    if (ir[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: in_ready=%b required 1", nm, ir[idx]);
    end
    iv[idx] = 1'b1;
    kt[idx] = v;
    ordy[idx] = 1'b0;
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    kt[idx] = 10'($urandom);
    lat = 0;
    while (!ov[idx] && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    n_run++;
    if (ov[idx] !== 1'b1 || lat !== elat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (valid=%b) required %0d",
               nm, lat, ov[idx], elat);
    end
    n_run++;
    if (int'(it[idx]) !== et) begin
      n_fail++;
      $display("FAIL %s type: got %0d required %0d", nm, it[idx], et);
    end
    n_run++;
    if (int'(vc[idx]) !== ec) begin
      n_fail++;
      $display("FAIL %s count: got %0d required %0d", nm, vc[idx], ec);
    end
    n_run++;
    if (ti[idx] !== etie) begin
      n_fail++;
      $display("FAIL %s tie: got %b required %b", nm, ti[idx], etie);
    end
    s_it = it[idx];
    s_vc = vc[idx];
    s_ti = ti[idx];
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      iv[idx] = 1'b1;
      kt[idx] = 10'($urandom);
      @(posedge clk); #1;
      if (ov[idx] !== 1'b1 || ir[idx] !== 1'b0 || it[idx] !== s_it ||
          vc[idx] !== s_vc || ti[idx] !== s_ti)
        bad = 1;
    end
    iv[idx] = 1'b0;
    if (hold > 0) begin
      n_run++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s hold: outputs moved got %b required 0", nm, bad);
      end
    end
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    n_run++;
    if (ov[idx] !== 1'b0 || ir[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: valid=%b ready=%b required 0 1",
               nm, ov[idx], ir[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hs%0d: ready=%b valid=%b required 1 0",
                 i, ir[i], ov[i]);
      end
      n_run++;
      if (it[i] !== 2'd0 || vc[i] !== 4'd0 || ti[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out%0d: type=%0d count=%0d tie=%b required 0",
                 i, it[i], vc[i], ti[i]);
      end
    end
  endtask

  task automatic test_basic();
    run_query(0, pk(2, 1, 2, 3, 2), 0, "basic");
  endtask

  task automatic test_tie();
    run_query(0, pk(3, 1, 1, 3, 0), 0, "tie_lowest");
    run_query(1, pk(3, 1, 1, 3, 0), 0, "tie_nearest");
  endtask

  task automatic test_backpressure();
    run_query(0, pk(0, 2, 1, 2, 3), 10, "backpressure");
  endtask

  task automatic test_reset_midflight();
    bit seen;
    iv[0] = 1'b1;
    kt[0] = pk(2, 2, 2, 2, 2);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_run++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || vc[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_state: ready=%b valid=%b count=%0d required 1 0 0",
               ir[0], ov[0], vc[0]);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) seen = 1;
    end
    n_run++;
    if (seen) begin
      n_fail++;
      $display("FAIL midreset_stale: out_valid seen=%b required 0", seen);
    end
    run_query(0, pk(0, 0, 1, 1, 0), 0, "after_reset");
  endtask

  task automatic test_ntypes();
    run_query(2, pk(3, 3, 3, 0, 1), 0, "nt3_tie");
    run_query(2, pk(3, 3, 3, 3, 3), 0, "nt3_invalid");
    run_query(0, pk(0, 0, 0, 0, 0), 0, "all_zero");
  endtask

  task automatic test_weight();
    run_query(0, pk(1, 2, 2, 0, 0), 0, "weight");
    run_query(1, pk(1, 2, 2, 0, 0), 0, "weight_near");
  endtask

  task automatic test_random();
    int idx;
    for (int r = 0; r < 40; r++) begin
      idx = $urandom_range(0, 2);
      run_query(idx, 10'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      kt[i] = '0;
      ordy[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_reset_midflight();
    test_ntypes();
    test_weight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/k_vote.md
Name: k_vote

Overview:
- Parametrised successor to the KNN type-inference voter.
- Takes the K sorted nearest-neighbour type labels from the sorter and counts votes per class, with optional rank weighting.
- Resolves ties by a selectable policy and returns the winning type, its vote total and a tie flag.
- Adds valid/ready handshakes on both sides so it sits between the sorter and the result sink with back-pressure.

Parameters:
- K, 5, number of neighbours per query (>=1).
- TYPE_W, 2, bits per type label.
- N_TYPES, 1<<TYPE_W, number of valid classes (<= 2^TYPE_W). Labels >= N_TYPES are ignored.
- TIE_MODE, 0, tie policy. 0 = lowest type index wins. 1 = type of nearest tied neighbour wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- in_valid  in  1  neighbour vector valid.
- in_ready  out  1  block can accept a query.
- k_types  in  TYPE_W*K  packed labels. Neighbour j is at [(j+1)*TYPE_W-1 -: TYPE_W]; j=0 is nearest.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- inferred_type  out  TYPE_W  winning class.
- vote_count  out  CNT_W  winning vote total. CNT_W = clog2(K*(K+1)/2+1).
- tie  out  1  more than one class reached the maximum.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0.
  - inferred_type=0, vote_count=0, tie=0.
  - All counters, indices and the captured vector cleared.
  - Applies from any state; an in-flight query is discarded and never reported.
- FSM states: IDLE, ACCUM, SCAN, TIE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture k_types, clear all N_TYPES counters, j=0, go to ACCUM.
  - k_types may change after the capture cycle.
- ACCUM: one neighbour per cycle, j=0..K-1 (K cycles).
  - If label < N_TYPES, count[label] += weight; otherwise no count.
  - Go to SCAN after j=K-1.
- SCAN: one class per cycle, t=0..N_TYPES-1 (N_TYPES cycles).
  - Track max and best.
  - Strict > updates best, so the lowest index wins on equality.
  - tie is set if a later count equals the current max and max > 0.
  - Exit: if tie && TIE_MODE==1 go to TIE, else OUT.
- TIE: walk j=0.. over the captured labels, one per cycle.
  - The first label < N_TYPES whose count==max becomes best; go to OUT.
  - Takes at most K cycles; a match is guaranteed.
- OUT:
  - inferred_type=best, vote_count=max, tie flag.
  - out_valid=1 and all outputs held stable until out_ready.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - No new query is accepted in the same cycle.
- in_ready is 1 only in IDLE; the block is single-query, no pipelining.
- Latency from accept to out_valid: 1+K+N_TYPES cycles, plus (matching tie index + 1) in TIE.
- All labels invalid (all >= N_TYPES): max=0, best=0, tie=0, vote_count=0.
- Counters are CNT_W wide and cannot overflow. K=1 is legal.

Optional Feature:
- Macro: K_VOTE_DIST_WEIGHT_EN.
- Defined: neighbour j contributes weight K-j (nearest = K, farthest = 1). Maximum total is K(K+1)/2.
- Undefined: every valid neighbour contributes 1. CNT_W remains sized for the weighted case so the ports are identical.

Decomposition:
- Shared package knn_pkg:
  - state enum (IDLE/ACCUM/SCAN/TIE/OUT);
  - TIE_MODE constants (TIE_LOWEST=0, TIE_NEAREST=1);
  - CNT_W computation function.
- No sub-module is needed. The counter bank plus argmax scan is one coherent FSM; an argmax sub-module would only add handshake overhead.

Test Plan (K=5, TYPE_W=2 unless noted; labels listed j0..j4):
- {2,1,2,3,2}, unweighted -> inferred_type=2, vote_count=3, tie=0, out_valid exactly 10 cycles after the accept edge.
- {3,1,1,3,0}, unweighted -> TIE_MODE=0: type 1, count 2, tie=1. TIE_MODE=1: type 3, count 2, tie=1.
- Valid result with out_ready held low 10 cycles -> outputs stable, in_ready=0, in_valid ignored. Release -> one-cycle handshake, then IDLE.
- Assert rst in ACCUM at j=2, then send {0,0,1,1,0} -> no stale out_valid; result type 0, count 3.
- N_TYPES=3, {3,3,3,0,1} -> type 0, count 1, tie=1. All {3,3,3,3,3} -> type 0, count 0, tie=0.
- {1,2,2,0,0} -> K_VOTE_DIST_WEIGHT_EN defined: type 2, count 7, tie=0. Undefined, TIE_MODE=0: type 0, count 2, tie=1.
